// File: rtl/ota_pkg.sv
// rtl/ota_pkg.sv - shared types and default constants for the OTA sigma-delta back end
package ota_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } ota_state_e;

  localparam int OTA_OSR_LOG2   = 8;
  localparam int OTA_OUT_W      = 8;
  localparam int OTA_SETTLE_CYC = 4;

endpackage

// File: rtl/ota_sync2.sv
// rtl/ota_sync2.sv - generic two-flop synchroniser for OTA-side asynchronous inputs
module ota_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ota_sd_decimator.sv
// rtl/ota_sd_decimator.sv - first-order sigma-delta loop closure and ones-count decimator
module ota_sd_decimator
  import ota_pkg::*;
#(
  parameter int OSR_LOG2   = OTA_OSR_LOG2,
  parameter int OUT_W      = OTA_OUT_W,
  parameter int SETTLE_CYC = OTA_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmp_in,
  input  logic             start,
  input  logic             continuous,
  output logic             dac_out,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             busy
);

  // Settle counter runs 0..SETTLE_CYC-1; keep at least one bit.
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam int SHIFT = OSR_LOG2 - OUT_W;

  logic cmp_s;

  ota_state_e            state_q, state_d;
  logic [SET_W-1:0]      settle_q, settle_d;
  logic [OSR_LOG2-1:0]   win_q, win_d;
  logic [OSR_LOG2:0]     acc_q, acc_d;
  logic [OUT_W-1:0]      sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  dac_q, dac_d;

  logic [OSR_LOG2:0]     acc_shr;
  logic [OUT_W:0]        code_full;
  logic [OUT_W-1:0]      code;

  ota_sync2 #(.WIDTH(1)) u_cmp_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (cmp_in),
    .q_o  (cmp_s)
  );

  // A full window of ones gives 2^OUT_W after scaling, which clips to all ones.
  assign acc_shr   = acc_q >> SHIFT;
  assign code_full = acc_shr[OUT_W:0];
  assign code      = code_full[OUT_W] ? {OUT_W{1'b1}} : code_full[OUT_W-1:0];

  // State, counters, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      win_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      dac_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      dac_q    <= dac_d;
    end
  end

  // Next-state logic; the DAC echoes cmp_s whenever the loop is active.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    win_d    = win_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    dac_d    = 1'b0;
    if (!ena) begin
      state_d  = ST_IDLE;
      settle_d = '0;
      win_d    = '0;
      acc_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
          end
        end
        ST_SETTLE: begin
          dac_d = cmp_s;
          if (settle_q == SET_LAST) begin
            state_d  = ST_CONVERT;
            settle_d = '0;
            win_d    = '0;
            acc_d    = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ST_CONVERT: begin
          dac_d = cmp_s;
          win_d = win_q + 1'b1;
          acc_d = acc_q + {{OSR_LOG2{1'b0}}, cmp_s};
          if (win_q == {OSR_LOG2{1'b1}}) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          dac_d    = cmp_s;
          sample_d = code;
          valid_d  = 1'b1;
          win_d    = '0;
          acc_d    = '0;
          state_d  = continuous ? ST_CONVERT : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign dac_out      = dac_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ota_sd_decimator.sv
// tb/tb_ota_sd_decimator.sv - directed self-checking bench for ota_sd_decimator
module tb_ota_sd_decimator;

  localparam int HIST = 8192;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       cmp_in;
  logic       start;
  logic       continuous;
  logic       dac_out;
  logic [7:0] sample;
  logic       sample_valid;
  logic       busy;

  int   checks;
  int   errors;
  int   cyc;
  int   pat_sel;
  logic hist [0:HIST-1];

  typedef struct {
    int         pat;
    logic [7:0] exp_sample;
  } vec_t;

  vec_t vecs [4];

  ota_sd_decimator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .cmp_in      (cmp_in),
    .start       (start),
    .continuous  (continuous),
    .dac_out     (dac_out),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: low, 1: high, 2: toggle every clock, 3: 25% duty
  function automatic logic pat_bit(input int pat, input int c);
    case (pat)
      1:       return 1'b1;
      2:       return c[0];
      3:       return (c % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cmp_in = pat_bit(pat_sel, cyc);
    hist[cyc % HIST] = cmp_in;
  endtask

  task automatic wait_valid(input int budget, output int n, output int dac_hi, output int dac_bad);
    n = 0;
    dac_hi = 0;
    dac_bad = 0;
    while (n < budget) begin
      tick();
      n++;
      if (dac_out) dac_hi++;
      if (n >= 4 && dac_out !== hist[(cyc - 3) % HIST]) dac_bad++;
      if (sample_valid) break;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n, hi, bad, vcount, vfirst, vsample, n2;
    checks = 0;
    errors = 0;
    cyc = 0;
    pat_sel = 0;
    rst_n = 1'b0;
    ena = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    cmp_in = 1'b0;

    vecs[0] = '{pat: 1, exp_sample: 8'd255};
    vecs[1] = '{pat: 0, exp_sample: 8'd0};
    vecs[2] = '{pat: 2, exp_sample: 8'd128};
    vecs[3] = '{pat: 3, exp_sample: 8'd64};

    repeat (3) tick();
    check("reset_dac", dac_out, 0);
    check("reset_sample", sample, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    ena = 1'b1;
    tick();

    // Single conversions over the vector table.
    for (int i = 0; i < 4; i++) begin
      pat_sel = vecs[i].pat;
      repeat (8) tick();
      pulse_start();
      check("busy_rise", busy, 1);
      wait_valid(400, n, hi, bad);
      check("latency", n, 261);
      check("sample", sample, vecs[i].exp_sample);
      tick();
      check("valid_pulse_width", sample_valid, 0);
      check("busy_fall", busy, 0);
      if (vecs[i].pat == 0) check("const_low_dac", hi, 0);
      if (vecs[i].pat == 2) check("alt_dac_delay3", bad, 0);
    end

    // Continuous mode at 25% duty, then clear continuous mid-window.
    pat_sel = 3;
    continuous = 1'b1;
    repeat (8) tick();
    pulse_start();
    wait_valid(400, n, hi, bad);
    check("cont_first_latency", n, 261);
    check("cont_first_sample", sample, 64);
    wait_valid(400, n, hi, bad);
    check("cont_spacing", n, 257);
    check("cont_second_sample", sample, 64);
    repeat (100) tick();
    continuous = 1'b0;
    wait_valid(400, n2, hi, bad);
    check("cont_last_spacing", 100 + n2, 257);
    check("cont_last_sample", sample, 64);
    tick();
    check("cont_end_idle", busy, 0);
    vcount = 0;
    repeat (300) begin
      tick();
      if (sample_valid) vcount++;
    end
    check("cont_no_extra_valid", vcount, 0);

    // Drop ena for one clock around window cycle 100.
    pat_sel = 1;
    repeat (8) tick();
    pulse_start();
    vcount = 0;
    repeat (104) begin
      tick();
      if (sample_valid) vcount++;
    end
    ena = 1'b0;
    tick();
    ena = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_dac", dac_out, 0);
    repeat (300) begin
      tick();
      if (sample_valid) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    check("abort_sample_kept", sample, 64);

    // start raised during CONVERT must not restart the conversion.
    pulse_start();
    n = 0;
    vfirst = -1;
    vsample = -1;
    vcount = 0;
    while (n < 300) begin
      tick();
      n++;
      if (n == 150) start = 1'b1;
      if (n == 151) start = 1'b0;
      if (sample_valid) begin
        vcount++;
        if (vfirst < 0) begin
          vfirst = n;
          vsample = sample;
        end
      end
    end
    check("restart_ignored_latency", vfirst, 261);
    check("restart_ignored_count", vcount, 1);
    check("restart_ignored_sample", vsample, 255);

    // Asynchronous reset in the middle of CONVERT.
    pat_sel = 2;
    repeat (8) tick();
    pulse_start();
    repeat (100) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_dac", dac_out, 0);
    check("arst_sample", sample, 0);
    check("arst_valid", sample_valid, 0);
    check("arst_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    pulse_start();
    wait_valid(400, n, hi, bad);
    check("post_reset_latency", n, 261);
    check("post_reset_sample", sample, 128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
